// File: rtl/a5200_pot_pkg.sv
// Shared types and default parameters for the 5200 POKEY pot-scan emulation.
// The scan FSM states, the count type and the channel/range defaults live here.
package a5200_pot_pkg;

    localparam int unsigned NCH     = 8;
    localparam int unsigned POT_MIN = 1;
    localparam int unsigned POT_MAX = 228;

    typedef enum logic [1:0] {PS_IDLE, PS_SCALE, PS_SCAN, PS_DONE} pot_state_t;

    typedef logic [7:0] pot_cnt_t;

endpackage

// File: rtl/pot_axis_scale.sv
// Registered axis-to-pot-count mapper. One multiplier is shared by all channels.
// The channel index and a valid flag travel with the result.
module pot_axis_scale #(
    parameter int unsigned POT_MIN = a5200_pot_pkg::POT_MIN,
    parameter int unsigned POT_MAX = a5200_pot_pkg::POT_MAX,
    parameter int unsigned IW      = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_vld,
    input  logic [IW-1:0] in_idx,
    input  logic [7:0]    axis,
    output logic          out_vld,
    output logic [IW-1:0] out_idx,
    output logic [7:0]    target
);
    import a5200_pot_pkg::*;

    localparam logic [15:0] SPAN    = 16'(POT_MAX - POT_MIN + 1);
    localparam pot_cnt_t    CNT_MIN = pot_cnt_t'(POT_MIN);

    logic          vld_d, vld_q;
    logic [IW-1:0] idx_d, idx_q;
    pot_cnt_t      tgt_d, tgt_q;

    // Flipping the sign bit turns -128..+127 into 0..255, so no signed multiply is needed.
    always_comb begin
        vld_d = in_vld & ~flush;
        idx_d = in_idx;
        tgt_d = CNT_MIN + 8'(({8'h00, axis ^ 8'h80} * SPAN) >> 8);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            idx_q <= '0;
            tgt_q <= '0;
        end else begin
            vld_q <= vld_d;
            idx_q <= idx_d;
            tgt_q <= tgt_d;
        end
    end

    assign out_vld = vld_q;
    assign out_idx = idx_q;
    assign target  = tgt_q;

endmodule

// File: rtl/pot_axis_scan.sv
// POKEY pot-scan emulation: snapshots the signed axes into pot targets on POTGO,
// then runs the scan counter and latches each channel's count as it is reached.
module pot_axis_scan #(
    parameter int unsigned NCH     = a5200_pot_pkg::NCH,
    parameter int unsigned POT_MIN = a5200_pot_pkg::POT_MIN,
    parameter int unsigned POT_MAX = a5200_pot_pkg::POT_MAX
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               POTGO,
    input  logic               LINE_STB,
    input  logic               FAST_STB,
    input  logic               FAST_SCAN,
    input  logic [NCH*8-1:0]   AXIS_IN,
    output logic [NCH-1:0]     POT_IN,
    output logic [NCH*8-1:0]   POT_VAL,
    output logic               SCAN_DONE,
    output logic               BUSY
);
    import a5200_pot_pkg::*;

    localparam int unsigned   IW       = (NCH > 1) ? $clog2(NCH) : 1;
    localparam pot_cnt_t      CNT_MAX  = pot_cnt_t'(POT_MAX);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

    pot_state_t          state_q, state_d;
    pot_cnt_t            cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [NCH-1:0]      tv_q, tv_d;
    logic [NCH-1:0]      pin_q, pin_d;
    logic [NCH-1:0][7:0] tgt_q, tgt_d;
    logic [NCH-1:0][7:0] val_q, val_d;
    logic [NCH-1:0][7:0] tgt_eff;
    logic                done_q, done_d;
    logic                scaling, counting, strobe, finish;

    logic                sc_vld;
    logic [IW-1:0]       sc_idx;
    pot_cnt_t            sc_tgt;

    pot_axis_scale #(
        .POT_MIN (POT_MIN),
        .POT_MAX (POT_MAX),
        .IW      (IW)
    ) u_scale (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .flush   (POTGO),
        .in_vld  (scaling),
        .in_idx  (idx_q),
        .axis    (AXIS_IN[idx_q*8 +: 8]),
        .out_vld (sc_vld),
        .out_idx (sc_idx),
        .target  (sc_tgt)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= PS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (POTGO) begin
            state_d = PS_SCALE;
        end else begin
            case (state_q)
                PS_SCALE: if (idx_q == LAST_IDX) state_d = PS_SCAN;
                PS_SCAN:  if (finish) state_d = PS_DONE;
                default:  state_d = state_q;
            endcase
        end
    end

    always_comb begin
        BUSY = (state_q == PS_SCALE) || (state_q == PS_SCAN);
    end

    always_comb begin
        scaling  = (state_q == PS_SCALE);
        counting = (state_q == PS_SCALE) || (state_q == PS_SCAN);
        strobe   = FAST_SCAN ? FAST_STB : LINE_STB;

        // A freshly scaled target is compared straight from the scaler output,
        // one cycle before it lands in the target bank.
        for (int unsigned i = 0; i < NCH; i++) begin
            tgt_eff[i] = (sc_vld && sc_idx == IW'(i)) ? sc_tgt : tgt_q[i];
        end

        cnt_d = cnt_q;
        if (counting && strobe && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end

        idx_d = scaling ? idx_q + IW'(1) : idx_q;
        tv_d  = tv_q;
        if (scaling) begin
            tv_d[idx_q] = 1'b1;
        end

        tgt_d = tgt_q;
        if (sc_vld) begin
            tgt_d[sc_idx] = sc_tgt;
        end

        pin_d = pin_q;
        val_d = val_q;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (tv_q[i] && !pin_q[i] && cnt_q >= tgt_eff[i]) begin
                pin_d[i] = 1'b1;
                val_d[i] = tgt_eff[i];
            end
        end

        finish = (state_q == PS_SCAN) && ((&pin_d) || (cnt_q == CNT_MAX && (&tv_q)));
        done_d = done_q;
        if (finish) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (!pin_d[i]) begin
                    val_d[i] = CNT_MAX;
                end
            end
            pin_d  = '1;
            done_d = 1'b1;
        end

        // Restart overrides any strobe or compare hit seen in the same cycle.
        if (POTGO) begin
            cnt_d  = '0;
            idx_d  = '0;
            tv_d   = '0;
            pin_d  = '0;
            val_d  = val_q;
            done_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            tv_q   <= '0;
            pin_q  <= '0;
            tgt_q  <= '0;
            val_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            tv_q   <= tv_d;
            pin_q  <= pin_d;
            tgt_q  <= tgt_d;
            val_q  <= val_d;
            done_q <= done_d;
        end
    end

    assign POT_IN    = pin_q;
    assign POT_VAL   = val_q;
    assign SCAN_DONE = done_q;

endmodule

// File: tb/tb_pot_axis_scan.sv
// Bench for pot_axis_scan: random strobes/axes against a cycle-level scan model
// computed directly from the signed-axis to pot-count rules.
module tb_pot_axis_scan;

    localparam int P_MIN = 1;
    localparam int P_MAX = 228;

    logic        CLK       = 1'b0;
    logic        RESET_N   = 1'b1;
    logic        POTGO     = 1'b0;
    logic        LINE_STB  = 1'b0;
    logic        FAST_STB  = 1'b0;
    logic        FAST_SCAN = 1'b0;
    logic [63:0] AXIS_IN   = '0;
    logic [7:0]  POT_IN;
    logic [63:0] POT_VAL;
    logic        SCAN_DONE;
    logic        BUSY;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    pot_axis_scan #(
        .NCH     (8),
        .POT_MIN (P_MIN),
        .POT_MAX (P_MAX)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .POTGO     (POTGO),
        .LINE_STB  (LINE_STB),
        .FAST_STB  (FAST_STB),
        .FAST_SCAN (FAST_SCAN),
        .AXIS_IN   (AXIS_IN),
        .POT_IN    (POT_IN),
        .POT_VAL   (POT_VAL),
        .SCAN_DONE (SCAN_DONE),
        .BUSY      (BUSY)
    );

    // Model: phase 0 idle, 1 snapshotting axes, 2 scanning, 3 done.
    int         m_phase;
    int         m_cnt;
    int         m_idx;
    int         m_tgt [8];
    logic [7:0] m_tv;
    logic [7:0] m_pin;
    logic [7:0] m_val [8];
    logic       m_done;

    function automatic int ref_target(input logic [7:0] ax);
        int s;
        s = int'($signed(ax));
        return P_MIN + ((s + 128) * (P_MAX - P_MIN + 1)) / 256;
    endfunction

    function automatic logic [63:0] exp_val();
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = m_val[i];
        return v;
    endfunction

    function automatic logic [9:0] exp_flags();
        return {m_pin, m_done, (m_phase == 1 || m_phase == 2)};
    endfunction

    task automatic m_reset();
        m_phase = 0;
        m_cnt   = 0;
        m_idx   = 0;
        m_tv    = '0;
        m_pin   = '0;
        m_done  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_tgt[i] = 0;
            m_val[i] = '0;
        end
    endtask

    task automatic m_step();
        logic [7:0] np;
        logic       fin;
        logic       stb;
        if (POTGO) begin
            m_cnt   = 0;
            m_idx   = 0;
            m_tv    = '0;
            m_pin   = '0;
            m_done  = 1'b0;
            m_phase = 1;
            return;
        end
        np = m_pin;
        for (int i = 0; i < 8; i++) begin
            if (m_tv[i] && !m_pin[i] && m_cnt >= m_tgt[i]) begin
                np[i]    = 1'b1;
                m_val[i] = 8'(m_tgt[i]);
            end
        end
        fin = (m_phase == 2) && (np == 8'hFF || (m_cnt == P_MAX && m_tv == 8'hFF));
        if (fin) begin
            for (int i = 0; i < 8; i++) if (!np[i]) m_val[i] = 8'(P_MAX);
            np     = 8'hFF;
            m_done = 1'b1;
        end
        m_pin = np;
        stb = FAST_SCAN ? FAST_STB : LINE_STB;
        if ((m_phase == 1 || m_phase == 2) && stb && m_cnt < P_MAX) m_cnt++;
        if (m_phase == 1) begin
            m_tgt[m_idx] = ref_target(AXIS_IN[8*m_idx +: 8]);
            m_tv[m_idx]  = 1'b1;
            m_idx++;
            if (m_idx == 8) m_phase = 2;
        end else if (fin) begin
            m_phase = 3;
        end
    endtask

    task automatic tick(input logic go, input logic ls, input logic fs);
        POTGO    = go;
        LINE_STB = ls;
        FAST_STB = fs;
        m_step();
        @(posedge CLK);
        #1;
        POTGO    = 1'b0;
        LINE_STB = 1'b0;
        FAST_STB = 1'b0;
    endtask

    task automatic test_reset();
        #2 RESET_N = 1'b0;
        #3;
        m_reset();
        total++; if (POT_IN !== 8'h00) begin bad++; $display("FAIL rst_pot_in got=%h exp=00", POT_IN); end
        total++; if (POT_VAL !== 64'h0) begin bad++; $display("FAIL rst_pot_val got=%h exp=0", POT_VAL); end
        total++; if ({SCAN_DONE, BUSY} !== 2'b00) begin bad++; $display("FAIL rst_done_busy got=%b exp=00", {SCAN_DONE, BUSY}); end
        @(negedge CLK);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        for (int c = 0; c < 6; c++) begin
            tick(1'b0, 1'($urandom), 1'($urandom));
            total++; if ({POT_IN, SCAN_DONE, BUSY} !== exp_flags()) begin bad++; $display("FAIL idle_flags got=%h exp=%h", {POT_IN, SCAN_DONE, BUSY}, exp_flags()); end
        end
    endtask

    task automatic test_slow_center();
        int nstb;
        FAST_SCAN = 1'b0;
        AXIS_IN   = '0;
        tick(1'b1, 1'b0, 1'b0);
        nstb = 0;
        for (int c = 0; c < 2000 && nstb < 120; c++) begin
            logic ls;
            ls = 1'($urandom_range(0, 1));
            if (ls) nstb++;
            tick(1'b0, ls, 1'($urandom));
            total++; if ({POT_IN, SCAN_DONE, BUSY} !== exp_flags()) begin bad++; $display("FAIL slow_flags got=%h exp=%h", {POT_IN, SCAN_DONE, BUSY}, exp_flags()); end
            total++; if (POT_VAL !== exp_val()) begin bad++; $display("FAIL slow_val got=%h exp=%h", POT_VAL, exp_val()); end
        end
        total++; if (POT_VAL !== {8{8'd115}}) begin bad++; $display("FAIL slow_final_val got=%h exp=all 73", POT_VAL); end
        total++; if ({POT_IN, SCAN_DONE} !== 9'h1FF) begin bad++; $display("FAIL slow_final_done got=%h exp=1ff", {POT_IN, SCAN_DONE}); end
    endtask

    task automatic test_fast_extremes();
        FAST_SCAN = 1'b1;
        for (int i = 3; i < 8; i++) AXIS_IN[8*i +: 8] = 8'($urandom);
        AXIS_IN[23:0] = {8'h00, 8'h7F, 8'h80};
        tick(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 700 && !m_done; c++) begin
            tick(1'b0, 1'($urandom), 1'($urandom_range(0, 1)));
            total++; if ({POT_IN, SCAN_DONE, BUSY} !== exp_flags()) begin bad++; $display("FAIL fast_flags got=%h exp=%h", {POT_IN, SCAN_DONE, BUSY}, exp_flags()); end
            total++; if (POT_VAL !== exp_val()) begin bad++; $display("FAIL fast_val got=%h exp=%h", POT_VAL, exp_val()); end
        end
        total++; if (POT_VAL[23:0] !== {8'd115, 8'd228, 8'd1}) begin bad++; $display("FAIL fast_extremes got=%h exp=73e401", POT_VAL[23:0]); end
        total++; if (SCAN_DONE !== 1'b1) begin bad++; $display("FAIL fast_done got=%b exp=1", SCAN_DONE); end
    endtask

    task automatic test_restart();
        logic [63:0] prior;
        FAST_SCAN = 1'b0;
        for (int i = 1; i < 8; i++) AXIS_IN[8*i +: 8] = 8'($urandom);
        AXIS_IN[7:0] = 8'h80;
        tick(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 50; c++) begin
            tick(1'b0, 1'b1, 1'($urandom));
            total++; if ({POT_IN, SCAN_DONE, BUSY} !== exp_flags()) begin bad++; $display("FAIL rs_flags got=%h exp=%h", {POT_IN, SCAN_DONE, BUSY}, exp_flags()); end
        end
        for (int i = 1; i < 8; i++) AXIS_IN[8*i +: 8] = 8'($urandom);
        prior = exp_val();
        tick(1'b1, 1'b1, 1'b0);
        total++; if ({POT_IN, SCAN_DONE, BUSY} !== 10'h001) begin bad++; $display("FAIL rs_clear got=%h exp=001", {POT_IN, SCAN_DONE, BUSY}); end
        total++; if (POT_VAL !== prior) begin bad++; $display("FAIL rs_hold got=%h exp=%h", POT_VAL, prior); end
        total++; if (POT_VAL[7:0] !== 8'd1) begin bad++; $display("FAIL rs_ch0_prior got=%h exp=01", POT_VAL[7:0]); end
        for (int c = 0; c < 3; c++) tick(1'b0, 1'b0, 1'b0);
        total++; if (POT_IN[0] !== 1'b0) begin bad++; $display("FAIL rs_cnt_zero got=%b exp=0", POT_IN[0]); end
        for (int c = 0; c < 1500 && !m_done; c++) begin
            tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom));
            total++; if ({POT_IN, SCAN_DONE, BUSY} !== exp_flags()) begin bad++; $display("FAIL rs2_flags got=%h exp=%h", {POT_IN, SCAN_DONE, BUSY}, exp_flags()); end
            total++; if (POT_VAL !== exp_val()) begin bad++; $display("FAIL rs2_val got=%h exp=%h", POT_VAL, exp_val()); end
        end
        total++; if (SCAN_DONE !== 1'b1) begin bad++; $display("FAIL rs2_done got=%b exp=1", SCAN_DONE); end
    endtask

    task automatic test_scale_catchup();
        FAST_SCAN = 1'b0;
        AXIS_IN   = {8{8'h80}};
        tick(1'b1, 1'b1, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            tick(1'b0, 1'b1, 1'b0);
            total++; if ({POT_IN, SCAN_DONE, BUSY} !== exp_flags()) begin bad++; $display("FAIL cu_flags got=%h exp=%h", {POT_IN, SCAN_DONE, BUSY}, exp_flags()); end
            if (c == 8) begin
                total++; if (POT_IN !== 8'h7F) begin bad++; $display("FAIL cu_before got=%h exp=7f", POT_IN); end
            end
            if (c == 9) begin
                total++; if ({POT_IN, SCAN_DONE} !== 9'h1FF) begin bad++; $display("FAIL cu_all got=%h exp=1ff", {POT_IN, SCAN_DONE}); end
                total++; if (POT_VAL !== {8{8'd1}}) begin bad++; $display("FAIL cu_val got=%h exp=all 01", POT_VAL); end
            end
        end
    endtask

    task automatic test_snapshot();
        FAST_SCAN = 1'b0;
        for (int i = 0; i < 8; i++) AXIS_IN[8*i +: 8] = 8'($urandom);
        AXIS_IN[31:24] = 8'h00;
        tick(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) tick(1'b0, 1'($urandom), 1'b0);
        AXIS_IN[31:24] = 8'h7F;
        for (int c = 0; c < 1500 && !m_done; c++) begin
            tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom));
            total++; if ({POT_IN, SCAN_DONE, BUSY} !== exp_flags()) begin bad++; $display("FAIL snap_flags got=%h exp=%h", {POT_IN, SCAN_DONE, BUSY}, exp_flags()); end
            total++; if (POT_VAL !== exp_val()) begin bad++; $display("FAIL snap_val got=%h exp=%h", POT_VAL, exp_val()); end
        end
        total++; if (POT_VAL[31:24] !== 8'd115) begin bad++; $display("FAIL snap_ch3 got=%0d exp=115", POT_VAL[31:24]); end
        tick(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 1500 && !m_done; c++) begin
            tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom));
            total++; if (POT_VAL !== exp_val()) begin bad++; $display("FAIL snap2_val got=%h exp=%h", POT_VAL, exp_val()); end
        end
        total++; if (POT_VAL[31:24] !== 8'd228) begin bad++; $display("FAIL snap2_ch3 got=%0d exp=228", POT_VAL[31:24]); end
    endtask

    task automatic test_async_reset();
        FAST_SCAN = 1'b0;
        for (int i = 0; i < 8; i++) AXIS_IN[8*i +: 8] = 8'h40 | 8'($urandom_range(0, 63));
        AXIS_IN[7:0] = 8'h80;
        tick(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 600 && m_cnt < 60; c++) begin
            tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            total++; if ({POT_IN, SCAN_DONE, BUSY} !== exp_flags()) begin bad++; $display("FAIL ar_flags got=%h exp=%h", {POT_IN, SCAN_DONE, BUSY}, exp_flags()); end
        end
        total++; if (m_cnt != 60) begin bad++; $display("FAIL ar_reach60 got=%0d exp=60", m_cnt); end
        #2 RESET_N = 1'b0;
        #1;
        m_reset();
        total++; if ({POT_IN, SCAN_DONE, BUSY} !== 10'h000) begin bad++; $display("FAIL ar_flags0 got=%h exp=000", {POT_IN, SCAN_DONE, BUSY}); end
        total++; if (POT_VAL !== 64'h0) begin bad++; $display("FAIL ar_val0 got=%h exp=0", POT_VAL); end
        @(negedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        for (int c = 0; c < 5; c++) begin
            tick(1'b0, 1'b1, 1'b1);
            total++; if ({POT_IN, SCAN_DONE, BUSY} !== exp_flags()) begin bad++; $display("FAIL ar_idle got=%h exp=%h", {POT_IN, SCAN_DONE, BUSY}, exp_flags()); end
        end
        tick(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 12; c++) begin
            tick(1'b0, 1'b0, 1'b0);
            total++; if ({POT_IN, SCAN_DONE, BUSY} !== exp_flags()) begin bad++; $display("FAIL ar_frozen got=%h exp=%h", {POT_IN, SCAN_DONE, BUSY}, exp_flags()); end
        end
        total++; if (POT_IN !== 8'h00) begin bad++; $display("FAIL ar_no_count got=%h exp=00", POT_IN); end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_slow_center();
        test_fast_extremes();
        test_restart();
        test_scale_catchup();
        test_snapshot();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
